// File: rtl/vga_text_pkg.sv
// Shared text-layer definitions.
// Glyph cell size, colour type and palette.
package vga_text_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  typedef logic [11:0] rgb12_t;

  localparam rgb12_t COL_BLACK = 12'h000;
  localparam rgb12_t COL_CYAN  = 12'h0FF;
  localparam rgb12_t COL_RED   = 12'hF00;

endpackage

// File: rtl/bcd_field_renderer_if.sv
// Raster timing in, overlay pixel out.
// slave = renderer, master = sync generator / mux side.
interface bcd_field_renderer_if;
  import vga_text_pkg::*;

  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       video_on;
  logic       hsync_in;
  logic       vsync_in;
  logic       frame_tick;
  rgb12_t     rgb;
  logic       pixel_on;
  logic       hsync_out;
  logic       vsync_out;

  modport master (
    output pix_x, pix_y, video_on,
    output hsync_in, vsync_in, frame_tick,
    input  rgb, pixel_on,
    input  hsync_out, vsync_out
  );

  modport slave (
    input  pix_x, pix_y, video_on,
    input  hsync_in, vsync_in, frame_tick,
    output rgb, pixel_on,
    output hsync_out, vsync_out
  );

endinterface

// File: rtl/digit_font_rom.sv
// Registered 8x16 seven-segment digit font.
// Codes 10..15 and unused rows read as blank.
module digit_font_rom (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit,
  input  logic [3:0] row,
  output logic [7:0] data
);

  // Bands {r13, r8-12, r7, r2-6, r1} per digit.
  function automatic logic [39:0] glyph(
    input logic [3:0] d
  );
    case (d)
      4'd0:    return 40'h7E_42_42_42_7E;
      4'd1:    return 40'h02_02_02_02_02;
      4'd2:    return 40'h7E_40_7E_02_7E;
      4'd3:    return 40'h7E_02_7E_02_7E;
      4'd4:    return 40'h02_02_7E_42_42;
      4'd5:    return 40'h7E_02_7E_40_7E;
      4'd6:    return 40'h7E_42_7E_40_7E;
      4'd7:    return 40'h02_02_02_02_7E;
      4'd8:    return 40'h7E_42_7E_42_7E;
      4'd9:    return 40'h7E_02_7E_42_7E;
      default: return 40'h0;
    endcase
  endfunction

  logic [39:0] g;
  logic [7:0]  sel;

  // Pick the band covering the requested row.
  always_comb begin
    g   = glyph(digit);
    sel = '0;
    unique case (1'b1)
      (row == 4'd1):                  sel = g[7:0];
      (row >= 4'd2 && row <= 4'd6):   sel = g[15:8];
      (row == 4'd7):                  sel = g[23:16];
      (row >= 4'd8 && row <= 4'd12):  sel = g[31:24];
      (row == 4'd13):                 sel = g[39:32];
      default:                        sel = '0;
    endcase
  end

  // Synchronous read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) data <= '0;
    else       data <= sel;
  end

endmodule

// File: rtl/bcd_field_renderer.sv
// Two-digit BCD field overlay, 3-cycle pixel pipe.
// Frame-shadowed data, blinking edit cursor.
module bcd_field_renderer
  import vga_text_pkg::*;
#(
  parameter int     NUM_FIELDS  = 3,
  parameter int     X0          = 96,
  parameter int     Y0          = 192,
  parameter int     FIELD_PITCH = 128,
  parameter int     SCALE_LOG2  = 2,
  parameter rgb12_t FG_RGB      = COL_CYAN,
  parameter rgb12_t HL_RGB      = COL_RED,
  parameter int     BLINK_LOG2  = 5
) (
  input  logic clk,
  input  logic reset,
  bcd_field_renderer_if.slave bus,
  input  logic [8*NUM_FIELDS-1:0] field_data,
  input  logic edit_on,
  input  logic [((NUM_FIELDS > 1) ?
    $clog2(NUM_FIELDS) : 1)-1:0] cursor_sel,
  input  logic blink_en
);

  localparam int CW =
    (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int GW = GLYPH_W << SCALE_LOG2;
  localparam int GH = GLYPH_H << SCALE_LOG2;
  localparam int unsigned YTOP = Y0;
  localparam int unsigned YBOT = Y0 + GH;

  typedef struct packed {
    logic       hit;
    logic       hl;
    logic       von;
    logic [3:0] nib;
    logic [2:0] col;
    logic [3:0] row;
  } s1_t;

  typedef struct packed {
    logic       hit;
    logic       hl;
    logic       von;
    logic [2:0] col;
  } s2_t;

  logic [8*NUM_FIELDS-1:0] shadow;
  logic [BLINK_LOG2:0]     blink_cnt;
  logic                    edit_q;
  logic                    blink_phase;
  logic                    cursor_ok;
  logic                    fsel;
  logic                    y_in;
  logic                    px_on;
  logic [31:0]             px;
  logic [31:0]             py;
  logic [7:0]              font_row;
  logic [2:0]              hs_sr;
  logic [2:0]              vs_sr;
  s1_t                     s1_d;
  s1_t                     s1_q;
  s2_t                     s2_q;

  function automatic int unsigned cell_x(
    input int f,
    input int d
  );
    return int'(unsigned'(X0 + f * FIELD_PITCH + d * GW));
  endfunction

  assign px          = 32'(bus.pix_x);
  assign py          = 32'(bus.pix_y);
  assign y_in        = (py >= YTOP) && (py < YBOT);
  assign cursor_ok   = 32'(cursor_sel) < 32'(NUM_FIELDS);
  assign blink_phase = ~blink_cnt[BLINK_LOG2];

  // Field data is latched once per frame only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               shadow <= '0;
    else if (bus.frame_tick) shadow <= field_data;
  end

  // Frame counter for blink; idle and edit entry clear it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      edit_q    <= 1'b0;
    end else begin
      edit_q <= edit_on;
      if (!edit_on || !edit_q)
        blink_cnt <= '0;
      else if (bus.frame_tick)
        blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Stage 1 hit test over every digit cell.
  always_comb begin
    s1_d     = '0;
    fsel     = 1'b0;
    s1_d.von = bus.video_on;
    s1_d.row = 4'((py - YTOP) >> SCALE_LOG2);
    for (int f = 0; f < NUM_FIELDS; f++) begin
      for (int d = 0; d < 2; d++) begin
        if (y_in && px >= cell_x(f, d) &&
            px < cell_x(f, d) + GW) begin
          s1_d.hit = 1'b1;
          s1_d.nib = shadow[8*f + 4*(1-d) +: 4];
          s1_d.col =
            3'((px - cell_x(f, d)) >> SCALE_LOG2);
          fsel = (CW'(f) == cursor_sel);
        end
      end
    end
    s1_d.hl = s1_d.hit & fsel & edit_on &
              cursor_ok & (blink_phase | ~blink_en);
  end

  // Stage 1 register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) s1_q <= '0;
    else       s1_q <= s1_d;
  end

  digit_font_rom u_rom (
    .clk   (clk),
    .reset (reset),
    .digit (s1_q.nib),
    .row   (s1_q.row),
    .data  (font_row)
  );

  // Stage 2 carries cell state beside the ROM read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) s2_q <= '0;
    else       s2_q <= '{hit: s1_q.hit, hl: s1_q.hl,
                         von: s1_q.von, col: s1_q.col};
  end

  assign px_on = font_row[~s2_q.col] &
                 s2_q.hit & s2_q.von;

  // Stage 3 colour select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rgb      <= COL_BLACK;
      bus.pixel_on <= 1'b0;
    end else begin
      bus.pixel_on <= px_on;
      bus.rgb      <= !px_on  ? COL_BLACK :
                      s2_q.hl ? HL_RGB : FG_RGB;
    end
  end

  // Sync delay matched to the pixel pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_sr <= '0;
      vs_sr <= '0;
    end else begin
      hs_sr <= {hs_sr[1:0], bus.hsync_in};
      vs_sr <= {vs_sr[1:0], bus.vsync_in};
    end
  end

  assign bus.hsync_out = hs_sr[2];
  assign bus.vsync_out = vs_sr[2];

endmodule

// File: doc/bcd_field_renderer.md
# bcd_field_renderer

Parametrised VGA overlay that draws NUM_FIELDS two-digit BCD fields (date, time or any RTC/PicoBlaze register set) at a configurable screen position and glyph scale. Pixel-pipelined with matched sync delay, it includes frame-synchronous shadowing of field data, an edit-mode cursor with blinking highlight, and blank rendering of non-BCD nibbles. It sits between the VGA sync generator and the RGB mux, beside the other text layers.

## Interface
- NUM_FIELDS, 3, number of two-digit fields (1..8)
- X0, 96, left x of field 0, pixels
- Y0, 192, top y of all fields, pixels
- FIELD_PITCH, 128, x distance between field starts; must be ≥ 2·GW
- SCALE_LOG2, 2, glyph magnification; GW = 8<<SCALE_LOG2, GH = 16<<SCALE_LOG2
- FG_RGB, 12'h0FF, normal digit colour
- HL_RGB, 12'hF00, cursor-field colour
- BLINK_LOG2, 5, highlight toggles every 2^BLINK_LOG2 frames
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- pix_x, pix_y  in  10 each  current pixel coordinates
- video_on, hsync_in, vsync_in  in  1 each  timing from sync generator
- frame_tick  in  1  one-cycle pulse, once per frame, during vertical blanking
- field_data  in  8·NUM_FIELDS  packed BCD; field f is [8f+7:8f], high nibble = left digit
- edit_on  in  1  programming mode active
- cursor_sel  in  max(1,$clog2(NUM_FIELDS))  field under edit
- blink_en  in  1  enables blinking of the cursor field
- rgb  out  12  pixel colour, 0 outside glyph foreground or when !video_on
- pixel_on  out  1  high when rgb is a foreground glyph pixel
- hsync_out, vsync_out  out  1 each  sync inputs delayed to align with rgb

## Operation
- Shadow: on frame_tick, shadow <= field_data. Rendering uses only the shadow, so there is no tearing mid-frame.
- Hit test (stage 1), for each field f and digit d∈{0,1}:
  - xs = X0 + f·FIELD_PITCH + d·GW.
  - Hit when xs ≤ pix_x < xs+GW and Y0 ≤ pix_y < Y0+GH.
  - At most one hit exists by construction. Register hit, f, d, nibble, col = (pix_x−xs)>>SCALE_LOG2 (3 b) and row = (pix_y−Y0)>>SCALE_LOG2 (4 b).
- Font (stage 2): synchronous ROM lookup of nibble/row gives an 8-bit row. Nibbles 10..15 read as 0, so non-BCD digits are blank.
- Pixel (stage 3): bit = row_data[7−col]; pixel_on = bit & hit & video_on.
- Colour: if !pixel_on, rgb = 0. Otherwise, if edit_on & (f==cursor_sel) & cursor_sel<NUM_FIELDS:
  - rgb = HL_RGB when blink_phase==1 or !blink_en;
  - rgb = FG_RGB when blink_phase==0 and blink_en.
  - All other foreground pixels use FG_RGB.
- Blink counter: BLINK_LOG2+1 bits. It increments on frame_tick while edit_on, and blink_phase = MSB inverted.
  - The counter clears to 0 on edit_on rising edge, so the first period shows HL.
  - The counter holds at 0 while !edit_on.
- edit_on, cursor_sel and blink_en are sampled in stage 1 and pipelined with the pixel, so a change takes effect from the next pixel.
- cursor_sel ≥ NUM_FIELDS: no highlight; all fields FG.

## Timing
- Latency: pix_x/pix_y/video_on/hsync_in/vsync_in in cycle n → rgb/pixel_on/hsync_out/vsync_out in cycle n+3. Syncs use a 3-deep shift register.
- Reset (async assert): rgb=0, pixel_on=0, hsync_out=0, vsync_out=0, shadow=0, blink counter=0, all pipeline hits=0. Release is synchronous to clk.
- frame_tick and an edit_on rising edge in the same cycle: the counter clears; the tick is not counted.
- Reset mid-frame: outputs are 0 until the pipeline refills (3 cycles). The shadow stays 0 (renders "00") until the first frame_tick.
- Coordinates are compared as unsigned 10-bit. Fields extending past 1023 are a configuration error; there is no wrap.

## Structure
- Shared package vga_text_pkg:
  - glyph width/height constants (8, 16);
  - the rgb12_t typedef;
  - colour constants (COL_BLACK, COL_CYAN, COL_RED).
- Sub-module digit_font_rom: 4-bit digit + 4-bit row in, 8-bit row data out, registered, blank for codes ≥ 10. It replaces the separate decoder+ROM pair used previously.
- The top module holds the shadow, hit logic, blink counter, 3-stage pipeline and sync delay.

## Test plan
- Defaults, field_data=24'h16_09_25, frame_tick once, raster scan → digits "25","09","16" drawn in 12'h0FF. Field 0 occupies x 96..159, y 192..255, and each pixel is 3 cycles late with matching syncs.
- Change field_data mid-frame without frame_tick → the image is unchanged until the next tick, then it updates.
- edit_on=1, cursor_sel=1, blink_en=1, BLINK_LOG2=1 → field 1 is red for 2 frames, cyan for 2, repeating. Fields 0 and 2 stay cyan. Dropping edit_on → immediate cyan.
- field_data nibble 4'hA in field 2 → that digit cell outputs rgb=0 for the whole glyph.
- cursor_sel=3 with NUM_FIELDS=3 → no red pixels. video_on=0 over a glyph → rgb=0, pixel_on=0.
- Assert reset asynchronously mid-line → all outputs 0 within the same cycle. After release, the first glyph pixel appears 3 cycles after its coordinate.
